// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges never-stalled load data with ALU results into one
// register-file write per cycle, buffering displaced ALU results in a FIFO.
module writeback_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [3:0]  alu_rd,
  input  logic [31:0] alu_wd,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [3:0]  mem_rd,
  input  logic [31:0] mem_wd,
  output logic        we3,
  output logic [3:0]  wa3,
  output logic [31:0] wd3,
  output logic        pc_we,
  output logic [31:0] pc_wd,
  output logic [14:0] busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0]       vld_q, vld_d;
  logic [DEPTH-1:0][3:0]  rd_q, rd_d;
  logic [DEPTH-1:0][31:0] wd_q, wd_d;
  logic [PW-1:0]          head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   we3_q, we3_d, pc_we_q, pc_we_d;
  logic [3:0]             wa3_q, wa3_d;
  logic [31:0]            wd3_q, wd3_d, pc_wd_q, pc_wd_d;

  logic        full, alu_acc, pop, push, sel;
  logic [3:0]  sel_rd;
  logic [31:0] sel_wd;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    vld_d   = vld_q;
    rd_d    = rd_q;
    wd_d    = wd_q;
    head_d  = head_q;
    tail_d  = tail_q;
    we3_d   = 1'b0;
    pc_we_d = 1'b0;
    wa3_d   = wa3_q;
    wd3_d   = wd3_q;
    pc_wd_d = pc_wd_q;
    pop     = 1'b0;
    push    = 1'b0;
    sel     = 1'b0;
    sel_rd  = '0;
    sel_wd  = '0;

    full      = (cnt_q == CW'(DEPTH));
    alu_ready = !full;
    alu_acc   = alu_valid && !full;

    // Squashed entries stay in the FIFO as holes and are retired at the head
    // without a write; a hole at the head is dropped for free under a load.
    if (mem_valid) begin
      sel    = 1'b1;
      sel_rd = mem_rd;
      sel_wd = mem_wd;
      pop    = (cnt_q != '0) && !vld_q[head_q];
      push   = alu_acc;
    end else if (cnt_q != '0) begin
      pop    = 1'b1;
      sel    = vld_q[head_q];
      sel_rd = rd_q[head_q];
      sel_wd = wd_q[head_q];
      push   = alu_acc;
    end else begin
      sel    = alu_acc;
      sel_rd = alu_rd;
      sel_wd = alu_wd;
    end

    if (mem_valid) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (rd_q[i] == mem_rd) vld_d[i] = 1'b0;
      end
    end

    if (pop) begin
      vld_d[head_q] = 1'b0;
      head_d        = ptr_inc(head_q);
    end
    if (push) begin
      vld_d[tail_q] = 1'b1;
      rd_d[tail_q]  = alu_rd;
      wd_d[tail_q]  = alu_wd;
      tail_d        = ptr_inc(tail_q);
    end
    cnt_d = cnt_q + CW'(push) - CW'(pop);

    if (sel) begin
      if (sel_rd == 4'hF) begin
        pc_we_d = 1'b1;
        pc_wd_d = sel_wd;
      end else begin
        we3_d = 1'b1;
        wa3_d = sel_rd;
        wd3_d = sel_wd;
      end
    end

    busy = '0;
    for (int unsigned n = 0; n < 15; n++) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (vld_q[i] && (rd_q[i] == 4'(n))) busy[n] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q   <= '0;
      rd_q    <= '0;
      wd_q    <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
      we3_q   <= 1'b0;
      wa3_q   <= '0;
      wd3_q   <= '0;
      pc_we_q <= 1'b0;
      pc_wd_q <= '0;
    end else begin
      vld_q   <= vld_d;
      rd_q    <= rd_d;
      wd_q    <= wd_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      we3_q   <= we3_d;
      wa3_q   <= wa3_d;
      wd3_q   <= wd3_d;
      pc_we_q <= pc_we_d;
      pc_wd_q <= pc_wd_d;
    end
  end

  assign we3   = we3_q;
  assign wa3   = wa3_q;
  assign wd3   = wd3_q;
  assign pc_we = pc_we_q;
  assign pc_wd = pc_wd_q;

endmodule
